// File: rtl/wb_interconnect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_interconnect_pkg
// Description : Shared definitions for the Wishbone NxN interconnect:
//               per-target arbiter FSM encoding and the id-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_interconnect_pkg;

    // Arbiter FSM encoding (explicit 2-bit width)
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_OWN  = 2'd1;
    localparam state_t c_ST_TOUT = 2'd2;

    // Width of a binary initiator index; never narrower than one bit so a
    // single-initiator build still has a legal gnt_id port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_pick
// Description : Combinational round-robin pick. Returns the first set req
//               bit at or above ptr, wrapping to the lowest set bit below ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_pick
    import wb_interconnect_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  index,
    output logic             any
);

    // Two priority passes: upper segment [ptr..N-1] first, then the wrap [0..ptr-1]
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any       = 1'b1;
                onehot[i] = 1'b1;
                index     = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (i < int'(ptr))) begin
                any       = 1'b1;
                onehot[i] = 1'b1;
                index     = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_target_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : wb_target_rr_arb
// Description : Per-target Wishbone arbiter. Registered round-robin grant,
//               held for the whole cyc, with a bus-timeout watchdog that
//               pulses an error to an owner whose target never answers.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_target_rr_arb
    import wb_interconnect_pkg::*;
#(
    parameter  int N_REQ          = 2,
    parameter  int TIMEOUT_CYCLES = 255,
    parameter  int TO_W           = 8,
    localparam int ID_W           = clog2_min1(N_REQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] cyc,
    input  logic             tack,
    input  logic             terr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic [N_REQ-1:0] tout_err
);

    localparam logic [TO_W-1:0] c_TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam bit              c_WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [ID_W-1:0] c_LAST_ID  = ID_W'(N_REQ - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  w_gnt_nxt;
    logic [ID_W-1:0]   r_gnt_id;
    logic [ID_W-1:0]   w_gnt_id_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic [N_REQ-1:0]  r_tout_err;
    logic [N_REQ-1:0]  w_tout_err_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [TO_W-1:0]   r_cnt;
    logic [TO_W-1:0]   w_cnt_nxt;

    logic [N_REQ-1:0]  w_pick_onehot;
    logic [ID_W-1:0]   w_pick_index;
    logic              w_pick_any;

    logic              w_own_cyc;
    logic              w_own_req;
    logic              w_ack_seen;
    logic [ID_W-1:0]   w_ptr_after;

    wb_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_pick_onehot),
        .index  (w_pick_index),
        .any    (w_pick_any)
    );

    // The one-hot grant selects the owner's cyc/req without an index mux
    assign w_own_cyc   = |(cyc & r_gnt);
    assign w_own_req   = |(req & r_gnt);
    assign w_ack_seen  = tack | terr;
    assign w_ptr_after = (r_gnt_id == c_LAST_ID) ? '0 : (r_gnt_id + ID_W'(1));

    // Next-state, grant and watchdog decisions
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_id_nxt   = r_gnt_id;
        w_busy_nxt     = r_busy;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
        w_tout_err_nxt = '0;

        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_pick_any) begin
                    w_state_nxt  = c_ST_OWN;
                    w_gnt_nxt    = w_pick_onehot;
                    w_gnt_id_nxt = w_pick_index;
                    w_busy_nxt   = 1'b1;
                end
            end

            c_ST_OWN: begin
                if (!w_own_cyc) begin
                    // Release has priority over any watchdog event this cycle
                    w_state_nxt = c_ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = w_ptr_after;
                    w_cnt_nxt   = '0;
                end else if (!c_WD_EN) begin
                    w_cnt_nxt = '0;
                end else if (!w_own_req || w_ack_seen) begin
                    // Idle strobe or a target answer restarts the wait window
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_TO_LIMIT) begin
                    w_state_nxt    = c_ST_TOUT;
                    w_tout_err_nxt = r_gnt;
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end

            c_ST_TOUT: begin
                w_cnt_nxt = '0;
                if (!w_own_cyc) begin
                    w_state_nxt = c_ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = w_ptr_after;
                end else begin
                    w_state_nxt = c_ST_OWN;
                end
            end

            default: begin
                w_state_nxt  = c_ST_IDLE;
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
                w_busy_nxt   = 1'b0;
                w_cnt_nxt    = '0;
            end
        endcase
    end

    // State, grant, pointer and watchdog registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_tout_err <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_busy     <= w_busy_nxt;
            r_tout_err <= w_tout_err_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign gnt_id   = r_gnt_id;
    assign busy     = r_busy;
    assign tout_err = r_tout_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_target_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_target_rr_arb
// Description : Self-checking bench for wb_target_rr_arb. A vector table and
//               directed sequences exercise a 2-initiator build (timeout 4)
//               alongside a watchdog-disabled twin; a 3-initiator build
//               (timeout 5) runs random traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_target_rr_arb;

    localparam int c_N_R = 3;
    localparam int c_T_R = 5;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic [1:0] r_req;
    logic [1:0] r_cyc;
    logic       r_tack;
    logic       r_terr;

    logic [1:0] w_gnt;
    logic [0:0] w_gnt_id;
    logic       w_busy;
    logic [1:0] w_tout;

    logic [1:0] w0_gnt;
    logic [0:0] w0_gnt_id;
    logic       w0_busy;
    logic [1:0] w0_tout;

    logic [2:0] r3_req;
    logic [2:0] r3_cyc;
    logic       r3_tack;
    logic       r3_terr;
    logic [2:0] w3_gnt;
    logic [1:0] w3_gnt_id;
    logic       w3_busy;
    logic [2:0] w3_tout;

    int n_checks = 0;
    int n_errors = 0;
    int n_tout0  = 0;

    wb_target_rr_arb #(.N_REQ(2), .TIMEOUT_CYCLES(4), .TO_W(8)) u_dut (
        .clock(r_clk), .reset(r_rst), .req(r_req), .cyc(r_cyc), .tack(r_tack), .terr(r_terr),
        .gnt(w_gnt), .gnt_id(w_gnt_id), .busy(w_busy), .tout_err(w_tout)
    );

    wb_target_rr_arb #(.N_REQ(2), .TIMEOUT_CYCLES(0), .TO_W(8)) u_dut_nowd (
        .clock(r_clk), .reset(r_rst), .req(r_req), .cyc(r_cyc), .tack(r_tack), .terr(r_terr),
        .gnt(w0_gnt), .gnt_id(w0_gnt_id), .busy(w0_busy), .tout_err(w0_tout)
    );

    wb_target_rr_arb #(.N_REQ(c_N_R), .TIMEOUT_CYCLES(c_T_R), .TO_W(4)) u_dut3 (
        .clock(r_clk), .reset(r_rst), .req(r3_req), .cyc(r3_cyc), .tack(r3_tack), .terr(r3_terr),
        .gnt(w3_gnt), .gnt_id(w3_gnt_id), .busy(w3_busy), .tout_err(w3_tout)
    );

    always #5 r_clk = ~r_clk;

    // The watchdog-disabled twin must never raise an error pulse
    always @(negedge r_clk) begin
        if (w0_tout != 2'b00) n_tout0++;
    end

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] cyc;
        logic       ack;
        logic       err;
        logic [1:0] gnt;
        logic       busy;
        logic [1:0] tout;
    } vec_t;

    vec_t tbl [16];

    // Reference model state for the random phase
    int m_owner = -1;
    bit m_tout  = 1'b0;
    int m_ptr   = 0;
    int m_wait  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] cyc,
                         input logic ack, input logic err);
        r_rst  = rst;
        r_req  = req;
        r_cyc  = cyc;
        r_tack = ack;
        r_terr = err;
    endtask

    // One clock edge of the arbitration rules, from the owner's point of view
    task automatic model_edge(input logic rst, input logic [2:0] req, input logic [2:0] cyc,
                              input logic ack, input logic err);
        if (rst) begin
            m_owner = -1;
            m_tout  = 1'b0;
            m_ptr   = 0;
            m_wait  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < c_N_R; k++) begin
                int cand;
                cand = (m_ptr + k) % c_N_R;
                if (m_owner < 0 && req[cand]) m_owner = cand;
            end
            m_wait = 0;
        end else if (!cyc[m_owner]) begin
            m_ptr   = (m_owner + 1) % c_N_R;
            m_owner = -1;
            m_tout  = 1'b0;
            m_wait  = 0;
        end else if (m_tout) begin
            m_tout = 1'b0;
            m_wait = 0;
        end else if (!req[m_owner] || ack || err) begin
            m_wait = 0;
        end else if (m_wait == c_T_R) begin
            m_tout = 1'b1;
        end else begin
            m_wait++;
        end
    endtask

    initial begin
        logic [1:0] lk;
        logic [2:0] exp3;

        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        r3_req  = 3'b000;
        r3_cyc  = 3'b000;
        r3_tack = 1'b0;
        r3_terr = 1'b0;

        // rst, req, cyc, ack, err  ->  gnt, busy, tout
        tbl[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00}; // reset state
        tbl[1]  = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00}; // grant after 1 cycle
        tbl[2]  = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00};
        tbl[3]  = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00};
        tbl[4]  = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00};
        tbl[5]  = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00}; // wait count reaches limit
        tbl[6]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00}; // cyc drop on limit: release
        tbl[7]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[8]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00}; // pointer moved to 1
        tbl[9]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00};
        tbl[10] = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00}; // owner 1 releases
        tbl[11] = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00};
        tbl[12] = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00};
        tbl[13] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[14] = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00};
        tbl[15] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].cyc, tbl[i].ack, tbl[i].err);
            step();
            chk($sformatf("tbl%0d_gnt", i),  32'(w_gnt),  32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_busy", i), 32'(w_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_tout", i), 32'(w_tout), 32'(tbl[i].tout));
            if (tbl[i].busy) chk($sformatf("tbl%0d_id", i), 32'(w_gnt_id), 32'(tbl[i].gnt[1]));
        end

        // Contention: grants alternate with one idle cycle between owners
        for (int g = 0; g < 4; g++) begin
            lk = (g % 2 == 0) ? 2'b01 : 2'b10;
            drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
            step();
            chk($sformatf("rr%0d_gnt", g), 32'(w_gnt), 32'(lk));
            chk($sformatf("rr%0d_busy", g), 32'(w_busy), 32'd1);
            repeat (2) begin
                step();
                chk($sformatf("rr%0d_hold", g), 32'(w_gnt), 32'(lk));
            end
            drive(1'b0, 2'b11 & ~lk, 2'b11 & ~lk, 1'b0, 1'b0);
            step();
            chk($sformatf("rr%0d_idle_gnt", g), 32'(w_gnt), 32'd0);
            chk($sformatf("rr%0d_idle_busy", g), 32'(w_busy), 32'd0);
        end

        // Lock: owner 0 gaps its strobe while initiator 1 keeps requesting
        drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        chk("lock_grant", 32'(w_gnt), 32'b01);
        for (int i = 0; i < 10; i++) begin
            lk = {1'b1, 1'(i % 2)};
            drive(1'b0, lk, 2'b11, 1'b0, 1'b0);
            step();
            chk($sformatf("lock%0d_gnt", i), 32'(w_gnt), 32'b01);
            chk($sformatf("lock%0d_tout", i), 32'(w_tout), 32'b00);
        end
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        step();
        chk("lock_release", 32'(w_gnt), 32'b00);

        // Timeout: pulses 5 edges after grant, then 5 watch cycles after each return to OWN
        drive(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
        step();
        chk("to_grant", 32'(w_gnt), 32'b01);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("to%0d_tout", k), 32'(w_tout),
                (k == 5 || k == 11 || k == 17) ? 32'b01 : 32'b00);
            chk($sformatf("to%0d_gnt", k), 32'(w_gnt), 32'b01);
        end
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        step();
        chk("to_release_gnt", 32'(w_gnt), 32'b00);
        chk("to_release_busy", 32'(w_busy), 32'd0);
        chk("to_release_tout", 32'(w_tout), 32'b00);

        // tack on the limit cycle suppresses the timeout and restarts the window
        drive(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
        step();
        chk("ack_grant", 32'(w_gnt), 32'b01);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 2'b01, 2'b01, (k == 5), 1'b0);
            step();
            chk($sformatf("ack%0d_tout", k), 32'(w_tout), (k == 10) ? 32'b01 : 32'b00);
        end
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        step();
        chk("ack_release", 32'(w_gnt), 32'b00);

        // Reset while initiator 1 owns the target; pointer returns to 0
        drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        chk("rst_pre_gnt", 32'(w_gnt), 32'b10);
        step();
        chk("rst_pre_hold", 32'(w_gnt), 32'b10);
        drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        chk("rst_gnt", 32'(w_gnt), 32'b00);
        chk("rst_busy", 32'(w_busy), 32'd0);
        drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        chk("rst_regrant", 32'(w_gnt), 32'b01);
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        step();

        // Long stall with the watchdog disabled
        drive(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
        repeat (1000) step();
        chk("nowd_gnt", 32'(w0_gnt), 32'b01);
        chk("nowd_busy", 32'(w0_busy), 32'd1);
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        step();
        chk("nowd_release", 32'(w0_gnt), 32'b00);

        // Random traffic on the 3-initiator build
        r_rst = 1'b1;
        model_edge(1'b1, r3_req, r3_cyc, r3_tack, r3_terr);
        step();
        chk("rnd_reset_gnt", 32'(w3_gnt), 32'd0);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < c_N_R; b++) begin
                if ($urandom_range(0, 7) == 0) r3_cyc[b] = ~r3_cyc[b];
                r3_req[b] = r3_cyc[b] && ($urandom_range(0, 7) != 0);
            end
            r3_tack = ($urandom_range(0, 11) == 0);
            r3_terr = ($urandom_range(0, 29) == 0);
            r_rst   = ($urandom_range(0, 299) == 0);
            model_edge(r_rst, r3_req, r3_cyc, r3_tack, r3_terr);
            step();
            exp3 = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            chk($sformatf("rnd%0d_gnt", c),  32'(w3_gnt),  32'(exp3));
            chk($sformatf("rnd%0d_busy", c), 32'(w3_busy), (m_owner >= 0) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_tout", c), 32'(w3_tout), m_tout ? 32'(exp3) : 32'd0);
            if (m_owner >= 0) chk($sformatf("rnd%0d_id", c), 32'(w3_gnt_id), 32'(m_owner));
        end
        r_rst = 1'b0;

        chk("nowd_tout_count", 32'(n_tout0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
